// File: rtl/mult_control.sv
// rtl/mult_control.sv - sequencing controller for the 8x8 multiplier built on one shared 4x4 multiplier
module mult_control (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       clk_ena,
    output logic       sclr_n,
    output logic       done,
    output logic [2:0] state_out
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LSB       = 3'd1;
    localparam logic [2:0] S_MID       = 3'd2;
    localparam logic [2:0] S_MSB       = 3'd3;
    localparam logic [2:0] S_CALC_DONE = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd5;

    logic [2:0] state_q, state_d;
    logic [1:0] count_q, count_d;
    logic       ena_raw;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        input_sel = 2'b00;
        shift_sel = 2'b00;
        ena_raw   = 1'b0;
        sclr_n    = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE, S_ERR: begin
                count_d = 2'd0;
                if (start) begin
                    ena_raw = 1'b1;
                    sclr_n  = 1'b0;
                    state_d = S_LSB;
                end
            end
            S_LSB: begin
                ena_raw = 1'b1;
                count_d = 2'd1;
                state_d = S_MID;
            end
            S_MID: begin
                input_sel = (count_q == 2'd1) ? 2'b01 : 2'b10;
                shift_sel = 2'b01;
                ena_raw   = 1'b1;
                count_d   = count_q + 2'd1;
                state_d   = (count_q == 2'd1) ? S_MID : S_MSB;
            end
            S_MSB: begin
                input_sel = 2'b11;
                shift_sel = 2'b10;
                ena_raw   = 1'b1;
                count_d   = 2'd0;
                state_d   = S_CALC_DONE;
            end
            S_CALC_DONE: begin
                done    = 1'b1;
                count_d = 2'd0;
                state_d = S_IDLE;
            end
            default: begin
                count_d = 2'd0;
                state_d = S_IDLE;
            end
        endcase

        // A start while busy aborts: no accumulation on this edge, park in ERR.
        if (start && (state_q == S_LSB || state_q == S_MID || state_q == S_MSB)) begin
            ena_raw = 1'b0;
            count_d = 2'd0;
            state_d = S_ERR;
        end
    end

    // Reset edges must never accumulate, even mid-operation.
    assign clk_ena   = ena_raw & ~reset;
    assign state_out = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - scoreboard bench for mult_control with a behavioural datapath model
module tb_mult_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic       clk_ena;
    logic       sclr_n;
    logic       done;
    logic [2:0] state_out;

    logic [7:0]  a, b;
    logic [15:0] acc;
    logic [3:0]  an, bn;
    logic [7:0]  pp;
    logic [15:0] shifted;

    logic [9:0]  exp_q[$];
    logic [15:0] prod_q[$];
    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    mult_control dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .input_sel (input_sel),
        .shift_sel (shift_sel),
        .clk_ena   (clk_ena),
        .sclr_n    (sclr_n),
        .done      (done),
        .state_out (state_out)
    );

    // Datapath: mux4 selectors, 4x4 multiplier, shifter, accumulator
    assign an = input_sel[1] ? a[7:4] : a[3:0];
    assign bn = input_sel[0] ? b[7:4] : b[3:0];
    assign pp = an * bn;
    assign shifted = (shift_sel == 2'b01) ? ({8'h00, pp} << 4) :
                     (shift_sel == 2'b10) ? ({8'h00, pp} << 8) : {8'h00, pp};

    always @(posedge clk) begin
        if (clk_ena) begin
            if (!sclr_n) acc <= 16'h0000;
            else         acc <= acc + shifted;
        end
    end

    // Monitor
    always @(negedge clk) begin
        logic [9:0]  e, got;
        logic [15:0] p;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {state_out, input_sel, shift_sel, clk_ena, sclr_n, done};
            vectors++;
            if (got !== e) begin
                fails++;
                $display("FAIL outputs t=%0t {state,isel,ssel,ena,sclr_n,done}: got %b required %b",
                         $time, got, e);
            end
        end
        if (done === 1'b1) begin
            vectors++;
            if (prod_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done t=%0t: got done=1 required no product pending", $time);
            end else begin
                p = prod_q.pop_front();
                if (acc !== p) begin
                    fails++;
                    $display("FAIL product t=%0t: got %h required %h", $time, acc, p);
                end
            end
        end
    end

    task automatic step(input logic st, input logic rs, input logic [2:0] s,
                        input logic [1:0] is, input logic [1:0] ss,
                        input logic en, input logic cl, input logic dn);
        @(posedge clk);
        #1;
        start = st;
        reset = rs;
        exp_q.push_back({s, is, ss, en, cl, dn});
    endtask

    // Full multiply from IDLE (from=0) or ERR (from=5); last_start drives start in CALC_DONE
    task automatic full_mult(input logic [7:0] av, input logic [7:0] bv,
                             input logic [15:0] prod, input logic [2:0] from,
                             input logic last_start);
        a = av;
        b = bv;
        prod_q.push_back(prod);
        step(1'b1, 1'b0, from, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd2, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd2, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd3, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0);
        step(last_start, 1'b0, 3'd4, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10; i++) idle_step();

        full_mult(8'hFF, 8'hFF, 16'hFE01, 3'd0, 1'b0);
        idle_step();
        full_mult(8'h5A, 8'h07, 16'h0276, 3'd0, 1'b0);
        idle_step();
        full_mult(8'h00, 8'hC3, 16'h0000, 3'd0, 1'b0);
        idle_step();

        // Abort in MID count=1, then restart from ERR
        a = 8'h12;
        b = 8'h34;
        step(1'b1, 1'b0, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd2, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd5, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd5, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        full_mult(8'h12, 8'h34, 16'h03A8, 3'd5, 1'b0);
        idle_step();

        // Reset during MSB
        a = 8'hA5;
        b = 8'h3C;
        step(1'b1, 1'b0, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd2, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd2, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd3, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0);
        idle_step();
        idle_step();
        full_mult(8'hA5, 8'h3C, 16'h26AC, 3'd0, 1'b0);

        // start held in CALC_DONE is ignored, then back-to-back products
        full_mult(8'h80, 8'h02, 16'h0100, 3'd0, 1'b1);
        idle_step();
        full_mult(8'hFF, 8'h01, 16'h00FF, 3'd0, 1'b0);
        full_mult(8'h5A, 8'h07, 16'h0276, 3'd0, 1'b0);
        idle_step();
        idle_step();

        @(posedge clk);
        #1;
        if (exp_q.size() != 0 || prod_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d outputs and %0d products pending required 0 and 0",
                     exp_q.size(), prod_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
